// File: rtl/alu_seq_flags.sv
// alu_seq_flags
//   Execute-stage ALU with a registered NZCV flag register and a valid/ready
//   operand handshake. Single-cycle ops (ADD, SUB, AND, ORR, EOR, ADC, SBC)
//   complete one cycle after acceptance. Opcode 111 is either an N-cycle
//   iterative shift-add multiplier or a single-cycle no-op.
//
//   Configuration macro: ALU_SEQ_MUL_EN
//     defined   -> opcode 111 runs the iterative multiplier (MUL state)
//     undefined -> opcode 111 writes result=0, leaves flags alone, 1 cycle
//
// Parameters
//   N          datapath width in bits (>= 4)
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-high; clears all state
//   in_valid   operands/opcode valid this cycle
//   in_ready   high only in IDLE; accept = in_valid & in_ready
//   alu_ctl    000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 ADC, 110 SBC, 111 MUL
//   a, b       operands
//   set_flags  write this op's flags into the flag register
//   result     registered result, holds until the next completion
//   out_valid  one-cycle pulse when result/flags are updated
//   flags      registered {N,Z,C,V}

module alu_seq_flags #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   alu_ctl,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         set_flags,
  output logic [N-1:0] result,
  output logic         out_valid,
  output logic [3:0]   flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  state_t state;
  state_t nextState;

  logic         accept;
  logic         execStart;
  logic [N-1:0] bEff;
  logic         cin;
  logic [N:0]   sum;
  logic [N-1:0] opResult;
  logic [3:0]   opFlags;
  logic         opWrites;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready;
  // Opcode 111 only bypasses the single-cycle path when the multiplier exists.
  assign execStart = accept & ~(MulEn & (alu_ctl == 3'b111));

  // Single-cycle datapath evaluated directly on the port operands. Because the
  // result and flags are registered on the accept edge, they appear in the EXEC
  // cycle together with out_valid. The carry-in comes from the flag register as
  // it stands on the accept edge, which is the latched C the ADC/SBC ops need.
  always_comb begin
    bEff     = b;
    cin      = 1'b0;
    opResult = '0;
    opFlags  = flags;
    opWrites = set_flags;
    case (alu_ctl)
      3'b001: begin bEff = ~b; cin = 1'b1;     end
      3'b101: begin bEff = b;  cin = flags[1]; end
      3'b110: begin bEff = ~b; cin = flags[1]; end
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, bEff} + {{N{1'b0}}, cin};
    case (alu_ctl)
      3'b000, 3'b001, 3'b101, 3'b110: begin
        opResult = sum[N-1:0];
        opFlags  = {sum[N-1], (sum[N-1:0] == '0), sum[N],
                    (a[N-1] == bEff[N-1]) & (sum[N-1] != a[N-1])};
      end
      3'b010, 3'b011, 3'b100: begin
        if (alu_ctl == 3'b010)      opResult = a & b;
        else if (alu_ctl == 3'b011) opResult = a | b;
        else                        opResult = a ^ b;
        opFlags = {opResult[N-1], (opResult == '0), flags[1:0]};
      end
      default: begin
        // Opcode 111 on the single-cycle path: zero result, flags untouched.
        opResult = '0;
        opWrites = 1'b0;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LastIter = CW'(N - 1);

  logic [N-1:0]  acc;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic          mulSetFlags;
  logic [N-1:0]  accNext;

  // One bit of the multiplier per cycle; the multiplicand shifts left so the
  // partial product lands at the right weight. Bits above N are dropped.
  assign accNext = acc + (mplier[0] ? mcand : '0);

  // Multiplier working registers: loaded on acceptance of opcode 111, then one
  // shift-add step per MUL cycle. The bit counter tells the FSM when to stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      mulSetFlags <= 1'b0;
    end else if (accept && (alu_ctl == 3'b111)) begin
      acc         <= '0;
      mcand       <= a;
      mplier      <= b;
      cnt         <= '0;
      mulSetFlags <= set_flags;
    end else if (state == MUL) begin
      acc    <= accNext;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`endif

  // State register. Reset mid-multiply simply drops back to IDLE, abandoning
  // the operation so no completion is ever signalled for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic: EXEC is always a single cycle; MUL lasts until the last
  // shift-add step, whose edge also returns to IDLE.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) nextState = execStart ? EXEC : MUL;
      end
      EXEC: nextState = IDLE;
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        if (cnt == LastIter) nextState = IDLE;
      end
`endif
      default: nextState = IDLE;
    endcase
  end

  // Architectural outputs: result, flags and the out_valid pulse. Single-cycle
  // ops commit on the accept edge; the multiplier commits on its final step,
  // taking N,Z from the product and keeping C,V as they were.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      flags     <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (execStart) begin
        result    <= opResult;
        out_valid <= 1'b1;
        if (opWrites) flags <= opFlags;
      end
`ifdef ALU_SEQ_MUL_EN
      if ((state == MUL) && (cnt == LastIter)) begin
        result    <= accNext;
        out_valid <= 1'b1;
        if (mulSetFlags) flags <= {accNext[N-1], (accNext == '0), flags[1:0]};
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_flags.sv
// tb_alu_seq_flags
//   Self-checking bench for alu_seq_flags at N=8. Each test task drives
//   operations; a reference model computes the expected result/flags and pushes
//   them to a scoreboard queue, which a negedge monitor pops whenever the DUT
//   pulses out_valid. Multiplier tests are built only with ALU_SEQ_MUL_EN.

module tb_alu_seq_flags;

  localparam int N = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_ctl;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         set_flags;
  logic [N-1:0] result;
  logic         out_valid;
  logic [3:0]   flags;

  typedef struct packed {
    logic [N-1:0] r;
    logic [3:0]   f;
  } exp_t;

  exp_t         sbq[$];
  exp_t         monE;
  logic [3:0]   mflags;
  int           total = 0;
  int           bad   = 0;

  alu_seq_flags #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctl   (alu_ctl),
    .a         (a),
    .b         (b),
    .set_flags (set_flags),
    .result    (result),
    .out_valid (out_valid),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_out_valid result=%h flags=%b", result, flags);
      end else begin
        monE = sbq.pop_front();
        total++;
        if (result !== monE.r) begin
          bad++;
          $display("[TB] FAIL sb_result got=%h want=%h", result, monE.r);
        end
        total++;
        if (flags !== monE.f) begin
          bad++;
          $display("[TB] FAIL sb_flags got=%b want=%b", flags, monE.f);
        end
      end
    end
  end

  // Reference model: uses plain integer arithmetic for carry and signed overflow.
  task automatic pushExpected(input logic [2:0] op, input logic [7:0] ia,
                              input logic [7:0] ib, input logic sf);
    logic [7:0] be;
    logic [7:0] r;
    logic [3:0] f;
    int c, us, sv;
    f = mflags;
    r = 8'h00;
    case (op)
      3'd0, 3'd1, 3'd5, 3'd6: begin
        be = (op == 3'd1 || op == 3'd6) ? ~ib : ib;
        c  = (op == 3'd0) ? 0 : (op == 3'd1) ? 1 : int'(mflags[1]);
        us = int'(ia) + int'(be) + c;
        sv = int'($signed(ia)) + int'($signed(be)) + c;
        r  = us[7:0];
        f  = {r[7], r == 8'h00, us > 255, (sv > 127) || (sv < -128)};
      end
      3'd2, 3'd3, 3'd4: begin
        r = (op == 3'd2) ? (ia & ib) : (op == 3'd3) ? (ia | ib) : (ia ^ ib);
        f = {r[7], r == 8'h00, mflags[1:0]};
      end
      default: begin
        if (MulEn) begin
          us = int'(ia) * int'(ib);
          r  = us[7:0];
          f  = {r[7], r == 8'h00, mflags[1:0]};
        end
      end
    endcase
    if (sf && !(op == 3'd7 && !MulEn)) mflags = f;
    sbq.push_back('{r: r, f: mflags});
  endtask

  // Drives one operation through the handshake and checks its latency.
  // With noise set, in_valid is toggled while the block is busy.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] ia,
                               input logic [7:0] ib, input logic sf, input bit noise);
    int w = 0;
    int lat;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) begin
      total++; bad++;
      $display("[TB] FAIL ready_timeout in_ready=%b want=1", in_ready);
    end
    alu_ctl = op; a = ia; b = ib; set_flags = sf; in_valid = 1'b1;
    pushExpected(op, ia, ib, sf);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = (op == 3'd7 && MulEn) ? N : 1;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      total++;
      if (i < lat) begin
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL busy_cycle%0d ready=%b valid=%b want=0,0", i, in_ready, out_valid);
        end
        if (noise) begin
          in_valid = i[0]; alu_ctl = 3'd0; a = 8'hFF; b = 8'h01; set_flags = 1'b1;
        end
      end else begin
        if (out_valid !== 1'b1) begin
          bad++;
          $display("[TB] FAIL latency op=%0d out_valid=%b want=1 at cycle %0d", op, out_valid, lat);
        end
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    #2;
    total++;
    if (result !== 8'h00 || flags !== 4'b0000 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state result=%h flags=%b ready=%b valid=%b want 00 0000 1 0",
               result, flags, in_ready, out_valid);
    end
    mflags = 4'b0000;
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus(3'd0, 8'h7F, 8'h01, 1'b1, 1'b0);
    doReset();
  endtask

  task automatic test_add_overflow();
    applyStimulus(3'd0, 8'h7F, 8'h01, 1'b1, 1'b0);
  endtask

  task automatic test_sub_and();
    applyStimulus(3'd1, 8'h05, 8'h05, 1'b1, 1'b0);
    applyStimulus(3'd2, 8'hF0, 8'h0F, 1'b1, 1'b0);
    total++;
    if (flags !== 4'b0110) begin
      bad++;
      $display("[TB] FAIL and_keeps_c flags=%b want=0110", flags);
    end
  endtask

  task automatic test_carry();
    applyStimulus(3'd0, 8'hFF, 8'h01, 1'b1, 1'b0);
    applyStimulus(3'd5, 8'h10, 8'h20, 1'b1, 1'b0);
    applyStimulus(3'd0, 8'hFF, 8'h01, 1'b1, 1'b0);
    applyStimulus(3'd5, 8'h10, 8'h20, 1'b0, 1'b0);
    total++;
    if (flags !== 4'b0110) begin
      bad++;
      $display("[TB] FAIL adc_noflags flags=%b want=0110", flags);
    end
    applyStimulus(3'd6, 8'h10, 8'h20, 1'b1, 1'b0);
    applyStimulus(3'd6, 8'h80, 8'h01, 1'b1, 1'b0);
  endtask

  task automatic test_logic();
    applyStimulus(3'd3, 8'h81, 8'h02, 1'b1, 1'b0);
    applyStimulus(3'd4, 8'hAA, 8'hAA, 1'b1, 1'b0);
    applyStimulus(3'd4, 8'h0F, 8'hF0, 1'b0, 1'b0);
  endtask

  task automatic test_mul();
    // Sets C and V first so their preservation across opcode 111 is visible.
    applyStimulus(3'd0, 8'h80, 8'h80, 1'b1, 1'b0);
    applyStimulus(3'd7, 8'h0C, 8'h0B, 1'b1, 1'b1);
    total++;
    if (result !== (MulEn ? 8'h84 : 8'h00)) begin
      bad++;
      $display("[TB] FAIL op111_result got=%h", result);
    end
    repeat (3) @(negedge clk);
    total++;
    if (sbq.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL noise_ignored pending=%0d valid=%b want 0 0", sbq.size(), out_valid);
    end
  endtask

  task automatic test_mul_reset();
    int seen = 0;
    @(negedge clk);
    alu_ctl = 3'd7; a = 8'h0C; b = 8'h0B; set_flags = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    doReset();
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0 || flags !== 4'b0000 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mul_abort pulses=%0d flags=%b ready=%b want 0 0000 1", seen, flags, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_ctl = 3'd0; a = '0; b = '0; set_flags = 1'b0;
    mflags = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_add_overflow();
    test_sub_and();
    test_carry();
    test_logic();
    test_mul();
`ifdef ALU_SEQ_MUL_EN
    test_mul_reset();
`endif
    test_back_to_back();
    repeat (4) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain pending=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
